cb_credit_tx: RTL and testbench
===============================

Name: cb_credit_tx

Overview:
- Credit-based transmit stage that sits directly upstream of the credit-based FIFO (`fifo`, DEPTH entries).
- Accepts words from a ready/valid producer and buffers them in a 2-entry skid buffer.
- Forwards words to the FIFO input only while it holds credits, so the FIFO can never overflow.
- Each FIFO pop (m_valid && m_ready) is returned to this block as a credit.

Parameters:
- Data_W, 32, data word width; must match the downstream FIFO.
- DEPTH, 8, downstream FIFO depth; also the initial and maximum credit count.
- MAX_RET, 1, maximum credits returned in one cycle via cr_count.
- CR_W, $clog2(MAX_RET+1), width of cr_count (derived; do not override).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer word valid.
- in_ready  out  1  space in skid buffer; registered.
- in_data  in  Data_W  producer word.
- tx_valid  out  1  word sent to FIFO s_valid this cycle; registered.
- tx_data  out  Data_W  word sent to FIFO s_data; registered.
- cr_valid  in  1  credit return strobe.
- cr_count  in  CR_W  number of credits returned when cr_valid=1.
- credits  out  $clog2(DEPTH+1)  current credit count.
- buf_level  out  2  skid buffer occupancy, 0..2.
- err_overflow  out  1  sticky error: credits would have exceeded DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - credits=DEPTH, buf_level=0, in_ready=0, tx_valid=0, tx_data=0, err_overflow=0.
  - in_ready rises on the first clock edge after rst_n deasserts.
  - Reset mid-operation drops buffered words and restores credits to DEPTH, with no tx_valid pulse. The downstream FIFO must be reset together with this block.
- Input handshake:
  - Push occurs when in_valid && in_ready at the edge.
  - in_ready = (buf_level_next < 2), registered. Full throughput is required: a push and a send may occur in the same edge.
  - Producer holds in_data stable while in_valid && !in_ready.
- Send decision (each edge):
  - send = (buf_level > 0) && (credits > 0), evaluated on the pre-edge values.
  - On send: tx_valid<=1, tx_data<=head word, head popped. Otherwise tx_valid<=0; tx_data holds its value.
  - tx_valid is a single-cycle pulse per word. There is no tx_ready: the credit guarantees the FIFO accepts it.
- Latency: a word pushed at edge N appears on tx at edge N+1 at the earliest, given credits>0 and nothing buffered ahead of it.
- Bypass: an empty buffer still takes one cycle; there is no combinational in-to-tx path.
- Order: strict FIFO order through the skid buffer; no drops, no duplicates.
- Credit arithmetic, computed in width $clog2(DEPTH+1)+1:
  - next = credits - send + (cr_valid ? cr_count : 0).
  - cr_valid with cr_count=0 is a no-op.
  - A simultaneous send and return of 1 leaves credits unchanged.
  - If next > DEPTH: credits<=DEPTH (saturate) and err_overflow<=1, which holds until reset.
  - credits never underflows, because send requires credits>0.
- Boundaries:
  - credits=0 with buf_level=2: in_ready=0 and no sends.
  - A return while credits=0 permits a send on the following edge, not the same edge.

Decomposition:
- Package cb_pkg holds:
  - credit width function cr_w(depth) = $clog2(depth+1);
  - a typedef for the buffer level;
  - the localparam SKID_DEPTH=2.
- One sub-module, cb_skid2: a 2-entry register buffer with push/pop/level. Credit logic and output registers stay in cb_credit_tx.

Test Plan:
- Reset, then push 1 word 0xA5A5_0001 with no returns → tx_valid pulses once, 1 cycle after the push edge, tx_data=0xA5A5_0001, credits=7.
- Push 10 words with no returns → exactly 8 tx pulses; credits=0; buf_level=2; in_ready=0. The 9th and 10th words are held and sent in order after 2 cr_valid pulses (cr_count=1), with credits returning to 0.
- Continuous push, plus cr_valid=1 every cycle starting the cycle after the first send → one send per cycle and credits steady at 7. Words 0xA5A5_1000..0xA5A5_100F appear in order.
- With credits=8, assert cr_valid with cr_count=1 → credits stays 8 and err_overflow=1 until rst_n=0.
- Assert rst_n=0 with buf_level=2 and credits=3 → immediately credits=8, buf_level=0, tx_valid=0, err_overflow=0.
- Drive this block into the real fifo (DEPTH=8) with random in_valid/m_ready for 1500 cycles, with cr_valid=m_valid&&m_ready → a scoreboard sees every word in order, FIFO s_ready is always 1 when tx_valid=1, and err_overflow stays 0.

Source files
------------

// File: rtl/cb_pkg.sv
// Shared types and helpers for the credit-based transmit stage.
package cb_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] level_t;

  function automatic int cr_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cb_credit_tx_if.sv
// Producer handshake, transmit and credit-return signals of cb_credit_tx.
interface cb_credit_tx_if #(
  parameter int Data_W = 32,
  parameter int CR_W   = 1
);
  logic              in_valid;
  logic              in_ready;
  logic [Data_W-1:0] in_data;
  logic              tx_valid;
  logic [Data_W-1:0] tx_data;
  logic              cr_valid;
  logic [CR_W-1:0]   cr_count;

  modport slave (
    input  in_valid, in_data, cr_valid, cr_count,
    output in_ready, tx_valid, tx_data
  );

  modport master (
    output in_valid, in_data, cr_valid, cr_count,
    input  in_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/cb_skid2.sv
// Two-entry register buffer, head always in e0; push and pop may share an edge.
// Caller guarantees no push when full and no pop when empty.
module cb_skid2
  import cb_pkg::*;
#(
  parameter int Data_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [Data_W-1:0] din,
  output logic [Data_W-1:0] head,
  output level_t            level,
  output level_t            level_nxt
);

  logic [Data_W-1:0] e0, e1;

  assign head = e0;

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + 2'd1;
    else if (!push && pop) level_nxt = level - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      level <= level_nxt;
      if (pop) begin
        e0 <= e1;
        // With one entry left the incoming word becomes the new head directly.
        if (push) begin
          if (level == 2'd1) e0 <= din;
          else               e1 <= din;
        end
      end else if (push) begin
        if (level == 2'd0) e0 <= din;
        else               e1 <= din;
      end
    end
  end

endmodule

// File: rtl/fifo.sv
// Generic ready/valid FIFO, DEPTH entries; registered storage, head visible combinationally.
// s_ready drops when full, m_valid drops when empty.
module fifo #(
  parameter int Data_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [Data_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [Data_W-1:0] m_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [Data_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic              wr_en, rd_en;

  assign s_ready = cnt < CW'(DEPTH);
  assign m_valid = cnt != '0;
  assign m_data  = mem[rd_ptr];
  assign wr_en   = s_valid && s_ready;
  assign rd_en   = m_valid && m_ready;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= inc(wr_ptr);
      if (rd_en) rd_ptr <= inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cb_credit_tx.sv
// Credit-gated transmit stage feeding a DEPTH-entry FIFO through a 2-entry skid buffer.
// One-cycle minimum in->tx latency; in_ready registered, sends stall while credits are 0.
module cb_credit_tx
  import cb_pkg::*;
#(
  parameter int Data_W  = 32,
  parameter int DEPTH   = 8,
  parameter int MAX_RET = 1,
  parameter int CR_W    = $clog2(MAX_RET + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cb_credit_tx_if.slave             bus,
  output logic [cr_w(DEPTH)-1:0]    credits,
  output level_t                    buf_level,
  output logic                      err_overflow
);

  localparam int CW = cr_w(DEPTH);
  typedef logic [CW-1:0] cred_t;
  typedef logic [CW:0]   sum_t;

  logic              push, send;
  logic [Data_W-1:0] head;
  level_t            level_nxt;
  logic [CR_W-1:0]   cr_cnt;
  sum_t              cr_add, cr_next;
  logic              over;

  assign cr_cnt = bus.cr_count;
  assign push   = bus.in_valid && bus.in_ready;
  assign send   = (buf_level != 2'd0) && (credits != '0);

  cb_skid2 #(.Data_W(Data_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (send),
    .din       (bus.in_data),
    .head      (head),
    .level     (buf_level),
    .level_nxt (level_nxt)
  );

  // One extra bit so a return on top of a full count is visible before saturation.
  always_comb begin
    cr_add  = bus.cr_valid ? sum_t'(cr_cnt) : '0;
    cr_next = sum_t'(credits) - sum_t'(send) + cr_add;
    over    = cr_next > sum_t'(DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits      <= cred_t'(DEPTH);
      err_overflow <= 1'b0;
      bus.in_ready <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= '0;
    end else begin
      credits      <= over ? cred_t'(DEPTH) : cr_next[CW-1:0];
      err_overflow <= err_overflow | over;
      bus.in_ready <= level_nxt < level_t'(SKID_DEPTH);
      bus.tx_valid <= send;
      if (send) bus.tx_data <= head;
    end
  end

endmodule

// File: tb/tb_cb_credit_tx.sv
// Directed and randomized bench for cb_credit_tx driving the generic fifo.
module tb_cb_credit_tx;
  import cb_pkg::*;

  localparam int DW      = 32;
  localparam int DEPTH   = 8;
  localparam int MAX_RET = 3;
  localparam int CRW     = $clog2(MAX_RET + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cb_credit_tx_if #(.Data_W(DW), .CR_W(CRW)) bus ();

  logic [3:0]    credits;
  level_t        buf_level;
  logic          err_overflow;
  logic          s_ready, m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic          link;
  logic          cr_valid_drv;
  logic [CRW-1:0] cr_count_drv;

  assign bus.cr_valid = link ? (m_valid && m_ready) : cr_valid_drv;
  assign bus.cr_count = link ? CRW'(m_valid && m_ready) : cr_count_drv;

  cb_credit_tx #(.Data_W(DW), .DEPTH(DEPTH), .MAX_RET(MAX_RET)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .credits      (credits),
    .buf_level    (buf_level),
    .err_overflow (err_overflow)
  );

  fifo #(.Data_W(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (bus.tx_valid),
    .s_ready (s_ready),
    .s_data  (bus.tx_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #2;
    total++; if (credits !== 4'd8) begin bad++; $display("FAIL rst_credits: got %0d want 8", credits); end
    total++; if (buf_level !== 2'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", buf_level); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid: got %b want 0", bus.tx_valid); end
    total++; if (bus.tx_data !== 32'h0) begin bad++; $display("FAIL rst_tx_data: got %h want 0", bus.tx_data); end
    total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_overflow); end
    step;
    rst_n = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL release_in_ready: got %b want 0", bus.in_ready); end
    step;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL first_edge_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hA5A5_0001;
    step;
    bus.in_valid = 1'b0;
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass: got %b want 0", bus.tx_valid); end
    total++; if (buf_level !== 2'd1) begin bad++; $display("FAIL single_level: got %0d want 1", buf_level); end
    step;
    total++; if (bus.tx_valid !== 1'b1) begin bad++; $display("FAIL single_tx_valid: got %b want 1", bus.tx_valid); end
    total++; if (bus.tx_data !== 32'hA5A5_0001) begin bad++; $display("FAIL single_tx_data: got %h want a5a50001", bus.tx_data); end
    total++; if (credits !== 4'd7) begin bad++; $display("FAIL single_credits: got %0d want 7", credits); end
    step;
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL single_pulse: got %b want 0", bus.tx_valid); end
    total++; if (bus.tx_data !== 32'hA5A5_0001) begin bad++; $display("FAIL single_hold: got %h want a5a50001", bus.tx_data); end
    cr_valid_drv = 1'b1; cr_count_drv = 2'd1;
    step;
    cr_valid_drv = 1'b1; cr_count_drv = 2'd0;
    total++; if (credits !== 4'd8) begin bad++; $display("FAIL single_return: got %0d want 8", credits); end
    step;
    cr_valid_drv = 1'b0;
    total++; if (credits !== 4'd8 || err_overflow !== 1'b0) begin bad++; $display("FAIL zero_return: got %0d/%b want 8/0", credits, err_overflow); end
  endtask

  task automatic test_fill;
    int idx = 0;
    int sent = 0;
    logic rdy;
    logic [DW-1:0] exp;
    for (int c = 0; c < 16; c++) begin
      bus.in_valid = (idx < 10);
      bus.in_data  = 32'hA5A5_2000 + idx;
      rdy = bus.in_ready;
      step;
      if (bus.in_valid && rdy) idx++;
      if (bus.tx_valid) begin
        exp = 32'hA5A5_2000 + sent;
        total++; if (bus.tx_data !== exp) begin bad++; $display("FAIL fill_order: got %h want %h", bus.tx_data, exp); end
        sent++;
      end
    end
    bus.in_valid = 1'b0;
    total++; if (idx !== 10) begin bad++; $display("FAIL fill_accepted: got %0d want 10", idx); end
    total++; if (sent !== 8) begin bad++; $display("FAIL fill_sends: got %0d want 8", sent); end
    total++; if (credits !== 4'd0) begin bad++; $display("FAIL fill_credits: got %0d want 0", credits); end
    total++; if (buf_level !== 2'd2) begin bad++; $display("FAIL fill_level: got %0d want 2", buf_level); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready: got %b want 0", bus.in_ready); end
    for (int k = 0; k < 2; k++) begin
      cr_valid_drv = 1'b1; cr_count_drv = 2'd1;
      step;
      cr_valid_drv = 1'b0;
      total++; if (bus.tx_valid !== 1'b0 || credits !== 4'd1) begin bad++; $display("FAIL ret_same_edge: got tx=%b cr=%0d want tx=0 cr=1", bus.tx_valid, credits); end
      step;
      exp = 32'hA5A5_2008 + k;
      total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp) begin bad++; $display("FAIL ret_send: got %b/%h want 1/%h", bus.tx_valid, bus.tx_data, exp); end
      total++; if (credits !== 4'd0) begin bad++; $display("FAIL ret_credits: got %0d want 0", credits); end
    end
    total++; if (buf_level !== 2'd0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL drained: got lvl=%0d rdy=%b want 0/1", buf_level, bus.in_ready); end
  endtask

  task automatic test_stream;
    logic [DW-1:0] exp;
    cr_valid_drv = 1'b1; cr_count_drv = 2'd1;
    for (int c = 0; c < 8; c++) step;
    cr_valid_drv = 1'b0;
    total++; if (credits !== 4'd8) begin bad++; $display("FAIL stream_pre_credits: got %0d want 8", credits); end
    for (int k = 1; k <= 18; k++) begin
      bus.in_valid = (k <= 16);
      bus.in_data  = 32'hA5A5_1000 + k - 1;
      cr_valid_drv = (k >= 3);
      cr_count_drv = 2'd1;
      step;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready: got %b want 1", bus.in_ready); end
      if (k >= 2 && k <= 17) begin
        exp = 32'hA5A5_1000 + k - 2;
        total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp) begin bad++; $display("FAIL stream_word: got %b/%h want 1/%h", bus.tx_valid, bus.tx_data, exp); end
        total++; if (credits !== 4'd7) begin bad++; $display("FAIL stream_credits: got %0d want 7", credits); end
      end
    end
    bus.in_valid = 1'b0;
    cr_valid_drv = 1'b0;
    total++; if (bus.tx_valid !== 1'b0 || credits !== 4'd8 || buf_level !== 2'd0) begin bad++; $display("FAIL stream_end: got tx=%b cr=%0d lvl=%0d want 0/8/0", bus.tx_valid, credits, buf_level); end
  endtask

  task automatic test_overflow;
    cr_valid_drv = 1'b1; cr_count_drv = 2'd1;
    step;
    cr_valid_drv = 1'b0;
    total++; if (credits !== 4'd8) begin bad++; $display("FAIL ovf_saturate: got %0d want 8", credits); end
    total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
    for (int c = 0; c < 3; c++) step;
    total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", err_overflow); end
  endtask

  task automatic test_reset_mid;
    int idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (credits == 4'd0 && buf_level == 2'd2) break;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hA5A5_3000 + idx;
      if (bus.in_ready) idx++;
      step;
    end
    bus.in_valid = 1'b0;
    cr_valid_drv = 1'b1; cr_count_drv = 2'd3;
    step;
    cr_valid_drv = 1'b0;
    total++; if (credits !== 4'd3 || buf_level !== 2'd2) begin bad++; $display("FAIL mid_pre: got cr=%0d lvl=%0d want 3/2", credits, buf_level); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (credits !== 4'd8) begin bad++; $display("FAIL mid_credits: got %0d want 8", credits); end
    total++; if (buf_level !== 2'd0) begin bad++; $display("FAIL mid_level: got %0d want 0", buf_level); end
    total++; if (bus.tx_valid !== 1'b0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_outputs: got tx=%b rdy=%b want 0/0", bus.tx_valid, bus.in_ready); end
    total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", err_overflow); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step;
      total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL mid_no_pulse: got %b want 0", bus.tx_valid); end
    end
  endtask

  task automatic test_fifo_random;
    logic [DW-1:0] expq[$];
    logic [DW-1:0] exp, got;
    int seq = 0;
    int pops = 0;
    logic acc = 1'b0;
    logic rdy, pop;
    link = 1'b1;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 1540; c++) begin
      if (c < 1500) begin
        if (!(bus.in_valid && !acc)) begin
          bus.in_valid = ($urandom_range(0, 3) != 0);
          bus.in_data  = 32'hB000_0000 + seq;
        end
        m_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
        m_ready = 1'b1;
      end
      #1;
      rdy = bus.in_ready;
      pop = m_valid && m_ready;
      got = m_data;
      if (bus.tx_valid) begin
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL fifo_space: got s_ready=%b want 1", s_ready); end
      end
      @(posedge clk);
      #1;
      acc = bus.in_valid && rdy;
      if (acc) begin expq.push_back(bus.in_data); seq++; end
      if (pop) begin
        pops++;
        total++;
        if (expq.size() == 0) begin bad++; $display("FAIL sb_extra: got %h want none", got); end
        else begin
          exp = expq.pop_front();
          if (got !== exp) begin bad++; $display("FAIL sb_order: got %h want %h", got, exp); end
        end
      end
    end
    link = 1'b0;
    total++; if (expq.size() != 0) begin bad++; $display("FAIL sb_left: got %0d want 0", expq.size()); end
    total++; if (pops < 300) begin bad++; $display("FAIL sb_traffic: got %0d pops want >=300", pops); end
    total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL rnd_err: got %b want 0", err_overflow); end
    total++; if (credits !== 4'd8 || buf_level !== 2'd0) begin bad++; $display("FAIL rnd_idle: got cr=%0d lvl=%0d want 8/0", credits, buf_level); end
  endtask

  initial begin
    link         = 1'b0;
    cr_valid_drv = 1'b0;
    cr_count_drv = '0;
    m_ready      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset;
    test_single;
    test_fill;
    test_stream;
    test_overflow;
    test_reset_mid;
    test_fifo_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
